// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT control sequencer.
//   fft_state_e : sequencer states
//   log2c       : ceil(log2(v)), usable in constant expressions
//   wb_delay    : read-to-write-back distance D = RD_LAT + BF_LAT
//   bitrev      : reverses the low w bits of v
package fft_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_UNLOAD,
    S_DONE
  } fft_state_e;

  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned wb_delay(input int unsigned rd_lat,
                                           input int unsigned bf_lat);
    return rd_lat + bf_lat;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v,
                                         input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// fft_addr_delay: DEPTH-stage shift register of {en, addr0, addr1}.
// Turns the butterfly read-address stream into the write-back stream.
//   clk, rst           : clock, synchronous active-high clear of all stages
//   i_en, i_addr0/1    : read enable and address pair entering the line
//   o_en, o_addr0/1    : the same values DEPTH cycles later
module fft_addr_delay #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  output logic          o_en,
  output logic [AW-1:0] o_addr0,
  output logic [AW-1:0] o_addr1
);

  logic [2*AW:0] r_line [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_line[i] <= '0;
    end else begin
      r_line[0] <= {i_en, i_addr0, i_addr1};
      for (int unsigned i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
    end
  end

  assign {o_en, o_addr0, o_addr1} = r_line[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// fft_sequencer: control for a radix-2 DIT FFT with ping-pong sample banks.
// Loads N samples (two per cycle) to bit-reversed addresses of bank 0, runs
// log2(N) stages of N/2 butterflies with delayed write-back to the other
// bank, then streams the result out in natural order. RD_LAT must be >= 1.
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : start pulse, honoured only when idle
//   in_valid_i        : input pair present during LOAD
//   src_sel_o         : bank write mux, 1 = external input, 0 = butterfly
//   rd_bank_o, rd_en_o, rd_addr0_o/1_o : bank read side
//   wr_en_o, wr_bank_o, wr_addr0_o/1_o : bank write side
//   twiddle_addr_o    : twiddle ROM address, aligned with rd_addr
//   bf_ce_o           : butterfly enable (compute reads delayed by RD_LAT)
//   stage_o, busy_o   : current stage, not-idle flag
//   out_valid_o       : output pair valid, done_o : end-of-run pulse
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned N      = 1024,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BF_LAT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         in_valid_i,
  output logic                         src_sel_o,
  output logic                         rd_bank_o,
  output logic                         rd_en_o,
  output logic [$clog2(N)-1:0]         rd_addr0_o,
  output logic [$clog2(N)-1:0]         rd_addr1_o,
  output logic                         wr_en_o,
  output logic                         wr_bank_o,
  output logic [$clog2(N)-1:0]         wr_addr0_o,
  output logic [$clog2(N)-1:0]         wr_addr1_o,
  output logic [$clog2(N/2)-1:0]       twiddle_addr_o,
  output logic                         bf_ce_o,
  output logic [$clog2($clog2(N)):0]   stage_o,
  output logic                         busy_o,
  output logic                         out_valid_o,
  output logic                         done_o
);

  localparam int unsigned L  = log2c(N);
  localparam int unsigned AW = L;
  localparam int unsigned IW = L - 1;
  localparam int unsigned SW = log2c(L) + 1;
  localparam int unsigned D  = wb_delay(RD_LAT, BF_LAT);
  localparam int unsigned WW = log2c(D + 1);

  localparam logic [IW-1:0] IDX_LAST   = IW'(N/2 - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(L - 1);
  localparam logic [WW-1:0] DRAIN_LAST = WW'(D - 1);
  localparam logic [WW-1:0] TAIL_LAST  = WW'(RD_LAT - 1);

  fft_state_e        r_state, w_state;
  logic [IW-1:0]     r_idx, w_idx;
  logic [SW-1:0]     r_stage, w_stage;
  logic              r_rd_bank, w_rd_bank;
  logic [WW-1:0]     r_wait, w_wait;
  logic              r_tail, w_tail;
  logic [RD_LAT-1:0] r_ce_pipe, r_ov_pipe;

  logic              w_rd_cmp, w_rd_unl;
  logic [AW-1:0]     w_j, w_half, w_pos, w_bfly_a0, w_ld_a0, w_ld_a1;
  logic [IW-1:0]     w_twiddle;
  logic              w_dly_en;
  logic [AW-1:0]     w_dly_a0, w_dly_a1;

  // Butterfly j of stage s: base = (j >> s) * 2^(s+1) + (j mod 2^s).
  assign w_j       = {1'b0, r_idx};
  assign w_half    = AW'(1) << r_stage;
  assign w_pos     = w_j & (w_half - AW'(1));
  assign w_bfly_a0 = ((w_j >> r_stage) << (r_stage + SW'(1))) | w_pos;
  assign w_twiddle = IW'(w_pos << (STAGE_LAST - r_stage));

  assign w_ld_a0 = AW'(bitrev(32'({r_idx, 1'b0}), AW));
  assign w_ld_a1 = AW'(bitrev(32'({r_idx, 1'b1}), AW));

  fft_addr_delay #(
    .DEPTH (D),
    .AW    (AW)
  ) u_addr_delay (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_rd_cmp),
    .i_addr0 (w_bfly_a0),
    .i_addr1 (w_bfly_a0 | w_half),
    .o_en    (w_dly_en),
    .o_addr0 (w_dly_a0),
    .o_addr1 (w_dly_a1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_stage   <= '0;
      r_rd_bank <= 1'b0;
      r_wait    <= '0;
      r_tail    <= 1'b0;
      r_ce_pipe <= '0;
      r_ov_pipe <= '0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_stage   <= w_stage;
      r_rd_bank <= w_rd_bank;
      r_wait    <= w_wait;
      r_tail    <= w_tail;
      r_ce_pipe <= RD_LAT'({r_ce_pipe, w_rd_cmp});
      r_ov_pipe <= RD_LAT'({r_ov_pipe, w_rd_unl});
    end
  end

  always_comb begin
    w_state        = r_state;
    w_idx          = r_idx;
    w_stage        = r_stage;
    w_rd_bank      = r_rd_bank;
    w_wait         = r_wait;
    w_tail         = r_tail;
    w_rd_cmp       = 1'b0;
    w_rd_unl       = 1'b0;
    src_sel_o      = 1'b0;
    rd_bank_o      = 1'b0;
    rd_en_o        = 1'b0;
    rd_addr0_o     = '0;
    rd_addr1_o     = '0;
    wr_en_o        = 1'b0;
    wr_bank_o      = 1'b0;
    wr_addr0_o     = '0;
    wr_addr1_o     = '0;
    twiddle_addr_o = '0;
    done_o         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state   = S_LOAD;
          w_idx     = '0;
          w_stage   = '0;
          w_rd_bank = 1'b0;
        end
      end
      S_LOAD: begin
        src_sel_o  = 1'b1;
        wr_en_o    = in_valid_i;
        wr_addr0_o = w_ld_a0;
        wr_addr1_o = w_ld_a1;
        if (in_valid_i) begin
          if (r_idx == IDX_LAST) begin
            w_state = S_COMPUTE;
            w_idx   = '0;
          end else begin
            w_idx = r_idx + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        rd_bank_o      = r_rd_bank;
        rd_en_o        = 1'b1;
        w_rd_cmp       = 1'b1;
        rd_addr0_o     = w_bfly_a0;
        rd_addr1_o     = w_bfly_a0 | w_half;
        twiddle_addr_o = w_twiddle;
        wr_en_o        = w_dly_en;
        wr_bank_o      = ~r_rd_bank;
        wr_addr0_o     = w_dly_a0;
        wr_addr1_o     = w_dly_a1;
        if (r_idx == IDX_LAST) begin
          w_state = S_DRAIN;
          w_wait  = '0;
        end else begin
          w_idx = r_idx + 1'b1;
        end
      end
      S_DRAIN: begin
        rd_bank_o  = r_rd_bank;
        wr_en_o    = w_dly_en;
        wr_bank_o  = ~r_rd_bank;
        wr_addr0_o = w_dly_a0;
        wr_addr1_o = w_dly_a1;
        if (r_wait == DRAIN_LAST) begin
          // Toggling after the last stage too leaves r_rd_bank on the
          // bank holding the final result, which UNLOAD reads.
          w_rd_bank = ~r_rd_bank;
          w_idx     = '0;
          if (r_stage == STAGE_LAST) begin
            w_state = S_UNLOAD;
            w_tail  = 1'b0;
          end else begin
            w_state = S_COMPUTE;
            w_stage = r_stage + 1'b1;
          end
        end else begin
          w_wait = r_wait + 1'b1;
        end
      end
      S_UNLOAD: begin
        rd_bank_o = r_rd_bank;
        if (!r_tail) begin
          rd_en_o    = 1'b1;
          w_rd_unl   = 1'b1;
          rd_addr0_o = {r_idx, 1'b0};
          rd_addr1_o = {r_idx, 1'b1};
          if (r_idx == IDX_LAST) begin
            w_tail = 1'b1;
            w_wait = '0;
          end else begin
            w_idx = r_idx + 1'b1;
          end
        end else if (r_wait == TAIL_LAST) begin
          w_state = S_DONE;
        end else begin
          w_wait = r_wait + 1'b1;
        end
      end
      S_DONE: begin
        done_o    = 1'b1;
        w_state   = S_IDLE;
        w_stage   = '0;
        w_rd_bank = 1'b0;
        w_idx     = '0;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign busy_o      = (r_state != S_IDLE);
  assign stage_o     = r_stage;
  assign bf_ce_o     = r_ce_pipe[RD_LAT-1];
  assign out_valid_o = r_ov_pipe[RD_LAT-1];

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
Control sequencer for the radix-2 DIT FFT butterfly datapath. It loads N input samples, two per cycle, into bit-reversed positions of a ping-pong pair of true-dual-port sample banks. It then runs log2(N) stages of N/2 butterflies each, generating read addresses, delayed write-back addresses, twiddle-ROM addresses and butterfly clock-enable. Finally it streams the result out in natural order. It replaces ad-hoc stage counting in the top-level FFT architecture and is the only block that drives bank addresses and enables.

Parameters:
N, 1024, FFT length, power of 2, minimum 8
RD_LAT, 1, read latency in cycles of the sample banks and twiddle ROMs
BF_LAT, 3, butterfly pipeline latency in cycles, from bf_ce input to result

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
start_i  in  1  one-cycle start pulse; honoured only in IDLE
in_valid_i  in  1  an input pair (samples 2m, 2m+1) is present this cycle during LOAD
src_sel_o  out  1  bank write-data mux: 1 = external input, 0 = butterfly output
rd_bank_o  out  1  bank read in the current stage; the other bank is written
rd_en_o  out  1  read enable, both ports of rd_bank_o
rd_addr0_o / rd_addr1_o  out  $clog2(N)  read addresses, port A / port B
wr_en_o  out  1  write enable, both ports of the write bank
wr_bank_o  out  1  bank written
wr_addr0_o / wr_addr1_o  out  $clog2(N)  write addresses, port A / port B
twiddle_addr_o  out  $clog2(N/2)  twiddle ROM address, issued in the same cycle as rd_addr
bf_ce_o  out  1  butterfly enable; equals rd_en delayed by RD_LAT during COMPUTE
stage_o  out  $clog2($clog2(N))+1  current stage index
busy_o  out  1  high in every state except IDLE
out_valid_o  out  1  output pair valid (bank data at natural addresses 2m, 2m+1)
done_o  out  1  one-cycle pulse after the last output pair

Behaviour:
- Reset: state = IDLE; all outputs 0; all counters 0; delay line cleared. Reset mid-operation aborts immediately with no further writes.
- L = log2(N). D = RD_LAT + BF_LAT.
- States: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD, DONE.
- IDLE -> LOAD on start_i. start_i is ignored in every other state.
- LOAD:
  - src_sel = 1; bank 0 is written (wr_bank = 0).
  - On each in_valid_i: wr_en = 1 in the same cycle, wr_addr0 = bitrev(2m), wr_addr1 = bitrev(2m+1); m increments.
  - After m = N/2-1 is written -> COMPUTE with s = 0, j = 0, rd_bank = 0.
  - Cycles without in_valid_i: wr_en = 0 and the state holds.
- COMPUTE, stage s, butterfly j = 0..N/2-1, one butterfly per cycle with rd_en = 1:
  - half = 2^s, grp = j>>s, pos = j & (half-1).
  - rd_addr0 = grp*2*half + pos; rd_addr1 = rd_addr0 + half.
  - twiddle_addr = pos << (L-1-s).
  - Write-back: wr_en, wr_addr0 and wr_addr1 equal rd_en, rd_addr0 and rd_addr1 delayed by exactly D cycles. wr_bank = !rd_bank; src_sel = 0.
  - After j = N/2-1 -> DRAIN.
- DRAIN:
  - rd_en = 0; wait D cycles until the stage's last write is issued.
  - Then if s < L-1: s++, j = 0, rd_bank toggles, -> COMPUTE. Otherwise -> UNLOAD.
  - Stage throughput is N/2 + D cycles. No read of stage s+1 overlaps a write of stage s.
- UNLOAD:
  - Read from the final bank F = L mod 2.
  - rd_addr0 = 2m, rd_addr1 = 2m+1 for m = 0..N/2-1, one pair per cycle.
  - out_valid_o follows rd_en by RD_LAT cycles.
  - After the last out_valid -> DONE.
- DONE: done_o = 1 for one cycle -> IDLE; busy_o = 0 from the next cycle.
- Counters wrap only by explicit reset at state transitions; no free-running wrap.
- Address widths are exact; no overflow is possible for legal N.

Decomposition:
- Package fft_pkg holds: state encoding localparams, a bitrev function parameterised by width, the log2 helper, and the definition of D.
- One sub-module, fft_addr_delay: a D-deep shift register of {en, addr0, addr1}, cleared by rst. It produces the write-back address stream.

Test Plan:
- Reset during COMPUTE stage 1, j = 2 -> next cycle: IDLE, busy = 0, rd_en = wr_en = 0; no write in the following D cycles.
- N=8 LOAD: pairs m = 0..3 with in_valid gaps -> wr_addr pairs (0,4), (2,6), (1,5), (3,7); wr_bank = 0; src_sel = 1; wr_en only on valid cycles.
- N=8 stage 0 -> rd pairs (0,1), (2,3), (4,5), (6,7), twiddle 0,0,0,0. Stage 1 -> (0,2), (1,3), (4,6), (5,7), twiddle 0,2,0,2. Stage 2 -> (0,4), (1,5), (2,6), (3,7), twiddle 0,1,2,3.
- N=8, RD_LAT=1, BF_LAT=3 -> each write pair appears exactly 4 cycles after its read, on the opposite bank. Each stage takes 8 cycles; rd_bank toggles 0,1,0.
- N=8 UNLOAD: reads bank 1 at (0,1), (2,3), (4,5), (6,7); out_valid for 4 consecutive cycles starting 1 cycle after the first read; done_o pulses once; busy_o drops the cycle after.
- start_i pulsed during COMPUTE and UNLOAD -> ignored; completion timing is unchanged. A back-to-back start_i in the cycle after done begins a new LOAD.
